// File: rtl/irq_ctrl_pkg.sv
// Shared register map, FSM state type and MASK reset value for irq_controller.
package irq_ctrl_pkg;

    localparam logic [31:0] IRQ_MASK_ADDR = 32'h0000_0080;
    localparam logic [31:0] IRQ_PEND_ADDR = 32'h0000_0084;
    localparam logic [31:0] IRQ_INSV_ADDR = 32'h0000_0088;

    localparam logic [31:0] IRQ_GLOBAL_EN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Global enable plus every implemented line enabled; doubles as the writable-bit mask.
    function automatic logic [31:0] irq_mask_rst(input int unsigned n_irq);
        return IRQ_GLOBAL_EN | ((32'h1 << n_irq) - 32'h1);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    always_comb begin
        o_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller/sequencer in front of CP0. Define IRQ_EDGE_DETECT_EN for sticky
// edge-captured PEND; the default build is level-sensitive (PEND follows i_irq).
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic             o_interrupt,
    output logic [ID_W-1:0]  o_irq_id,
    output logic             o_busy
);

    localparam logic [31:0] MASK_RST = irq_mask_rst(N_IRQ);

    logic [31:0]      r_mask;
    irq_state_e       r_state;
    logic             r_interrupt;
    logic             r_busy;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_IRQ-1:0] w_pend;
    logic [N_IRQ-1:0] w_elig;
    logic [N_IRQ-1:0] w_id_onehot;
    logic             w_cur_elig;
    logic             w_valid;
    logic [ID_W-1:0]  w_win_id;
    logic             w_mask_we;
    logic [31:0]      w_rdata;

    assign w_mask_we   = i_we && (i_addr == IRQ_MASK_ADDR);
    assign w_elig      = w_pend & r_mask[N_IRQ-1:0] & {N_IRQ{r_mask[31]}};
    assign w_id_onehot = N_IRQ'(1) << r_irq_id;
    assign w_cur_elig  = |(w_elig & w_id_onehot);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mask <= MASK_RST;
        end else if (w_mask_we) begin
            r_mask <= i_data & MASK_RST;
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] w_clr;
    logic             w_pend_we;

    assign w_pend_we = i_we && (i_addr == IRQ_PEND_ADDR);

    always_comb begin
        w_clr = '0;
        if (w_pend_we) begin
            w_clr = i_data[N_IRQ-1:0];
        end
        if ((r_state == REQ) && i_ack) begin
            w_clr = w_clr | w_id_onehot;
        end
    end

    // A fresh capture is ORed in after clearing so it wins over W1C/ack in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= i_irq;
            r_pend <= (r_pend & ~w_clr) | (i_irq & ~r_prev);
        end
    end

    assign w_pend = r_pend;
`else
    assign w_pend = i_irq;
`endif

    irq_prio_enc #(
        .N    (N_IRQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .i_req   (w_elig),
        .o_valid (w_valid),
        .o_id    (w_win_id)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_interrupt <= 1'b0;
            r_busy      <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state     <= REQ;
                        r_irq_id    <= w_win_id;
                        r_interrupt <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                REQ: begin
                    // Ack wins: once the core has latched EPC the request is committed.
                    if (i_ack) begin
                        r_state     <= SERVICE;
                        r_interrupt <= 1'b0;
                    end else if (!w_cur_elig) begin
                        r_state     <= IDLE;
                        r_interrupt <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (i_eret) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_interrupt <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_addr)
            IRQ_MASK_ADDR: w_rdata = r_mask;
            IRQ_PEND_ADDR: w_rdata[N_IRQ-1:0] = w_pend;
            IRQ_INSV_ADDR: begin
                if (r_state == SERVICE) begin
                    w_rdata[31]       = 1'b1;
                    w_rdata[ID_W-1:0] = r_irq_id;
                end
            end
            default: w_rdata = '0;
        endcase
    end

    assign o_data      = w_rdata;
    assign o_interrupt = r_interrupt;
    assign o_irq_id    = r_irq_id;
    assign o_busy      = r_busy;

endmodule
